// File: rtl/psdsqrt_pkg.sv
// Shared types and constants for the psdsqrt scheduler.
package psdsqrt_pkg;

  localparam int unsigned NREQ = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_STOP,
    ST_CAPT,
    ST_DONE
  } state_t;

  // Number of core iterations between start and stop.
  function automatic int unsigned sqrt_cycles(input int unsigned nbitsin, input int unsigned k);
    return (nbitsin + k) / 2;
  endfunction

endpackage

// File: rtl/psdsqrt_sched_if.sv
// Client request/response and psdsqrt core signals of the scheduler.
interface psdsqrt_sched_if import psdsqrt_pkg::*; #(
  parameter int unsigned NBITSIN = 32
);
  localparam int unsigned NOUT = NBITSIN / 2;

  logic [NREQ-1:0]    req;
  logic [NBITSIN-1:0] x0;
  logic [NBITSIN-1:0] x1;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    done;
  logic [NOUT-1:0]    result;
  logic               grant_id;
  logic               busy;
  logic               sq_start;
  logic               sq_stop;
  logic [NBITSIN-1:0] sq_xin;
  logic [NOUT-1:0]    sq_sqrt;

  modport master (
    output req, x0, x1, sq_sqrt,
    input  ack, done, result, grant_id, busy, sq_start, sq_stop, sq_xin
  );

  modport slave (
    input  req, x0, x1, sq_sqrt,
    output ack, done, result, grant_id, busy, sq_start, sq_stop, sq_xin
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered last-served pointer.
module rr_arbiter2 import psdsqrt_pkg::*; (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            update,
  output logic            grant_c,
  output logic            valid_c
);

  logic last_q;

  always_comb begin
    valid_c = |req;
    grant_c = 1'b0;
    unique case (req)
      2'b01:   grant_c = 1'b0;
      2'b10:   grant_c = 1'b1;
      2'b11:   grant_c = ~last_q;
      default: grant_c = 1'b0;
    endcase
  end

  // Reset value marks requester 1 as last served so requester 0 wins first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      last_q <= 1'b1;
    else if (update) last_q <= grant_c;
  end

endmodule

// File: rtl/psdsqrt_sched.sv
// Shares one psdsqrt core between two requesters; sequences start/stop and returns the root.
module psdsqrt_sched import psdsqrt_pkg::*; #(
  parameter int unsigned NBITSIN     = 32,
  parameter int unsigned K           = 8,
  parameter int unsigned SQRT_CYCLES = sqrt_cycles(NBITSIN, K)
) (
  input logic           clock,
  input logic           reset,
  psdsqrt_sched_if.slave bus
);

  localparam int unsigned NOUT = NBITSIN / 2;
  localparam int unsigned CW   = $clog2(SQRT_CYCLES + 1);

  state_t             state_q, state_n;
  logic [CW-1:0]      cnt_q;
  logic               gnt_c, gnt_valid_c, arb_update_c, grant_n_c;
  logic               grant_q;
  logic [NBITSIN-1:0] xin_q;
  logic [NOUT-1:0]    result_q;
  logic [NREQ-1:0]    ack_q, done_q;
  logic               busy_q, start_q, stop_q;

  assign arb_update_c = (state_q == ST_IDLE) && gnt_valid_c;
  assign grant_n_c    = arb_update_c ? gnt_c : grant_q;

  rr_arbiter2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (bus.req),
    .update  (arb_update_c),
    .grant_c (gnt_c),
    .valid_c (gnt_valid_c)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      ST_IDLE:  if (gnt_valid_c) state_n = ST_START;
      ST_START: state_n = ST_RUN;
      ST_RUN:   if (cnt_q <= CW'(1)) state_n = ST_STOP;
      ST_STOP:  state_n = ST_CAPT;
      ST_CAPT:  state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      grant_q  <= 1'b0;
      xin_q    <= '0;
      result_q <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      if (arb_update_c) begin
        grant_q <= gnt_c;
        xin_q   <= gnt_c ? bus.x1 : bus.x0;
      end
      if (state_q == ST_START)    cnt_q <= CW'(SQRT_CYCLES);
      else if (state_q == ST_RUN) cnt_q <= cnt_q - CW'(1);
      if (state_q == ST_CAPT) result_q <= bus.sq_sqrt;
      ack_q   <= (state_n == ST_START) ? (NREQ'(1) << grant_n_c) : '0;
      done_q  <= (state_n == ST_DONE)  ? (NREQ'(1) << grant_q)   : '0;
      busy_q  <= (state_n != ST_IDLE);
      start_q <= (state_n == ST_START);
      stop_q  <= (state_n == ST_STOP);
    end
  end

  assign bus.ack      = ack_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;
  assign bus.sq_start = start_q;
  assign bus.sq_stop  = stop_q;
  assign bus.sq_xin   = xin_q;

endmodule

// File: tb/tb_psdsqrt_sched.sv
// Scoreboard bench for psdsqrt_sched with a behavioural psdsqrt core attached.
module tb_psdsqrt_sched;
  import psdsqrt_pkg::*;

  typedef struct packed {
    logic        id;
    logic [15:0] res;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  int   total_done = 0;
  int   done_cyc [2];
  exp_t sb [$];

  psdsqrt_sched_if #(.NBITSIN(32)) bus ();

  psdsqrt_sched #(.NBITSIN(32), .K(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    logic [15:0] r;
    logic [15:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'd1 << b);
      if (64'(t) * 64'(t) <= 64'(x)) r = t;
    end
    return r;
  endfunction

  // Behavioural core: output register loads at the end of the stop cycle.
  initial bus.sq_sqrt = '0;
  always @(posedge clock) if (bus.sq_stop) bus.sq_sqrt <= isqrt(bus.sq_xin);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected response.
  always @(negedge clock) begin
    if (bus.done != 2'b00) begin
      exp_t e;
      total_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(bus.done), 64'd0);
      end else begin
        e = sb.pop_front();
        check("done_vec", 64'(bus.done), 64'(2'b01 << e.id));
        check("done_grant_id", 64'(bus.grant_id), 64'(e.id));
        check("done_result", 64'(bus.result), 64'(e.res));
        done_cyc[e.id] = cyc;
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    bus.req = 2'b00;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Runs until the scoreboard empties and the block is idle, dropping req bits on ack.
  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < budget) begin
      @(negedge clock);
      bus.req = bus.req & ~bus.ack;
      n++;
    end
    check(name, 64'(n < budget), 64'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int g, ack_n, ack_at, start_n, start_at, stop_n, stop_at, done_n, done_at;
    int busy_n, busy_first, busy_last, k, dn, saved;
    logic [1:0] ack_v;
    logic       fair_seq [4];

    bus.req = 2'b00;
    bus.x0  = '0;
    bus.x1  = '0;

    // Held in reset with both requests asserted: nothing may move.
    bus.req = 2'b11;
    bus.x0  = 32'd9;
    bus.x1  = 32'd16;
    repeat (4) begin
      @(negedge clock);
      check("rst_ctl", 64'({bus.ack, bus.done, bus.sq_start, bus.sq_stop, bus.busy}), 64'd0);
      check("rst_result", 64'(bus.result), 64'd0);
      check("rst_xin", 64'(bus.sq_xin), 64'd0);
    end
    bus.req = 2'b00;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Single request with cycle-exact timing.
    ack_n = 0; ack_at = -1; start_n = 0; start_at = -1; stop_n = 0; stop_at = -1;
    done_n = 0; done_at = -1; busy_n = 0; busy_first = -1; busy_last = -1; ack_v = '0;
    bus.x0  = 32'd123456;
    bus.req = 2'b01;
    sb.push_back(exp_t'{id: 1'b0, res: 16'd351});
    g = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.ack != 2'b00) begin
        if (ack_n == 0) begin ack_at = cyc; ack_v = bus.ack; end
        ack_n++;
        bus.req = 2'b00;
      end
      if (bus.sq_start) begin start_n++; start_at = cyc; end
      if (bus.sq_stop)  begin stop_n++;  stop_at  = cyc; end
      if (bus.done != 2'b00) begin done_n++; done_at = cyc; end
      if (bus.busy) begin
        if (busy_n == 0) busy_first = cyc;
        busy_n++;
        busy_last = cyc;
      end
    end
    check("t2_ack_cycle", 64'(ack_at - g), 64'd1);
    check("t2_ack_vec", 64'(ack_v), 64'd1);
    check("t2_ack_count", 64'(ack_n), 64'd1);
    check("t2_start_cycle", 64'(start_at - g), 64'd1);
    check("t2_start_count", 64'(start_n), 64'd1);
    check("t2_stop_cycle", 64'(stop_at - g), 64'd22);
    check("t2_stop_count", 64'(stop_n), 64'd1);
    check("t2_done_cycle", 64'(done_at - g), 64'd24);
    check("t2_done_count", 64'(done_n), 64'd1);
    check("t2_busy_first", 64'(busy_first - g), 64'd1);
    check("t2_busy_last", 64'(busy_last - g), 64'd24);
    check("t2_busy_count", 64'(busy_n), 64'd24);
    check("t2_sb_empty", 64'(sb.size()), 64'd0);

    // Simultaneous requests after reset: requester 0 first.
    do_reset();
    bus.x0  = 32'd12;
    bus.x1  = 32'd13;
    bus.req = 2'b11;
    sb.push_back(exp_t'{id: 1'b0, res: 16'd3});
    sb.push_back(exp_t'{id: 1'b1, res: 16'd3});
    drain("t3_timeout", 100);
    check("t3_spacing", 64'(done_cyc[1] - done_cyc[0]), 64'd25);

    // Fairness with both requests held high across four services.
    do_reset();
    fair_seq[0] = 1'b0; fair_seq[1] = 1'b1; fair_seq[2] = 1'b0; fair_seq[3] = 1'b1;
    bus.x0 = 32'd100;
    bus.x1 = 32'd400;
    sb.push_back(exp_t'{id: 1'b0, res: 16'd10});
    sb.push_back(exp_t'{id: 1'b1, res: 16'd20});
    sb.push_back(exp_t'{id: 1'b0, res: 16'd10});
    sb.push_back(exp_t'{id: 1'b1, res: 16'd20});
    bus.req = 2'b11;
    k = 0; dn = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (bus.ack != 2'b00) begin
        if (k < 4) check("t4_grant_seq", 64'(bus.grant_id), 64'(fair_seq[k]));
        k++;
      end
      if (bus.done != 2'b00) dn++;
      if (dn == 4) begin
        bus.req = 2'b00;
        break;
      end
    end
    drain("t4_timeout", 60);
    check("t4_services", 64'(k), 64'd4);

    // Operand changes after the grant must not reach the core.
    do_reset();
    bus.x0  = 32'd1057;
    bus.req = 2'b01;
    sb.push_back(exp_t'{id: 1'b0, res: 16'd32});
    repeat (10) begin
      @(negedge clock);
      bus.req = bus.req & ~bus.ack;
    end
    bus.x0 = 32'd4291;
    check("t5_xin_hold_a", 64'(bus.sq_xin), 64'd1057);
    repeat (5) @(negedge clock);
    check("t5_xin_hold_b", 64'(bus.sq_xin), 64'd1057);
    drain("t5_timeout", 60);

    // Reset in the middle of RUN drops the operation without a done pulse.
    do_reset();
    bus.x0  = 32'd1057;
    bus.req = 2'b01;
    g = cyc;
    while (cyc < g + 10) begin
      @(negedge clock);
      bus.req = bus.req & ~bus.ack;
    end
    check("t6_busy_before", 64'(bus.busy), 64'd1);
    saved = total_done;
    reset = 1'b0;
    #1;
    check("t6_async_ctl", 64'({bus.sq_start, bus.sq_stop, bus.busy, bus.ack, bus.done}), 64'd0);
    repeat (3) begin
      @(negedge clock);
      check("t6_rst_ctl", 64'({bus.sq_start, bus.sq_stop, bus.busy, bus.done}), 64'd0);
    end
    reset = 1'b1;
    repeat (30) @(negedge clock);
    check("t6_no_done", 64'(total_done - saved), 64'd0);
    check("t6_idle", 64'(bus.busy), 64'd0);
    bus.x0  = 32'd4291;
    bus.req = 2'b01;
    sb.push_back(exp_t'{id: 1'b0, res: 16'd65});
    drain("t6_timeout", 60);

    repeat (2) @(negedge clock);
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psdsqrt_sched.md
Name: psdsqrt_sched

Overview:
- Sequencer and 2-way round-robin arbiter that shares one psdsqrt square-root core between two requesters.
- Latches the granted operand and drives the core's start/stop pulses with exact cycle timing.
- Captures the core result and returns it with a per-requester done pulse.
- Sits between client logic and a single psdsqrt instance; replaces hand-timed start/stop sequencing.

Parameters:
- NBITSIN, 32, operand width; must be even.
- k, 8, extra core iterations; must match the attached psdsqrt.
- SQRT_CYCLES, (NBITSIN+k)/2, RUN-state length in cycles; must be >= 1.

Ports:
- clock  in  1  master clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  2  level request per requester; held until ack.
- x0  in  NBITSIN  operand of requester 0.
- x1  in  NBITSIN  operand of requester 1.
- ack  out  2  one-cycle pulse; operand has been latched.
- done  out  2  one-cycle pulse; result is valid.
- result  out  NBITSIN/2  last captured root; held until the next capture.
- grant_id  out  1  requester currently or last served.
- busy  out  1  high whenever state != IDLE.
- sq_start  out  1  to psdsqrt start.
- sq_stop  out  1  to psdsqrt stop.
- sq_xin  out  NBITSIN  to psdsqrt xin.
- sq_sqrt  in  NBITSIN/2  from psdsqrt sqrt.

Behaviour:
- All outputs are registered and Moore-style (a function of the current state plus held registers).
- Reset (reset=0) acts immediately, not on an edge. It forces:
  - state to IDLE;
  - ack, done, sq_start, sq_stop and busy to 0;
  - result, sq_xin and grant_id to 0;
  - the round-robin pointer so that requester 0 has priority.
- Reset mid-operation: the operation is dropped with no done pulse and is not replayed. psdsqrt's own reset is not driven by this block.
- FSM states: IDLE, START, RUN, STOP, CAPT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: grant it, load sq_xin with x[grant], set grant_id, go to START.
  - Both requests active: grant the requester not served last. After reset, requester 0 wins.
  - The pointer updates on every grant.
- START (1 cycle): sq_start=1 and ack[grant_id]=1. Load the cycle counter with SQRT_CYCLES. Go to RUN.
- RUN (SQRT_CYCLES cycles): decrement the counter; leave for STOP when it reaches 0.
- STOP (1 cycle): sq_stop=1. psdsqrt loads its output register at the end of this cycle.
- CAPT (1 cycle): load result with sq_sqrt at the end of the cycle.
- DONE (1 cycle): done[grant_id]=1; result is valid. Return to IDLE.
- sq_xin holds constant from the grant until the next grant. Operand changes on x0/x1 after the grant are ignored.
- Latency, with the request sampled in IDLE cycle g:
  - ack and sq_start in cycle g+1;
  - sq_stop in cycle g+SQRT_CYCLES+2;
  - done in cycle g+SQRT_CYCLES+4.
  - Defaults: sq_stop at g+22, done at g+24.
- Back-to-back service: DONE is followed by an IDLE arbitration cycle, so the minimum done-to-done spacing is SQRT_CYCLES+5 (25 with defaults).
- A request withdrawn before it is granted is discarded silently.
- A request arriving during an operation waits.
- A requester's req seen in its own DONE cycle is treated as a new request.

Decomposition:
- Shared package psdsqrt_pkg holds:
  - the state enum/localparams;
  - a default-SQRT_CYCLES function of NBITSIN and k;
  - the requester-count constant.
- Natural sub-module: rr_arbiter2 (combinational grant plus a registered last-served pointer, with an update enable).
- The counter and FSM stay in the top.

Test Plan:
- Reset check: hold reset=0 and drive req=2'b11 -> ack, done, sq_start, sq_stop and busy stay 0 throughout; result=0.
- Single request: after reset release, req0 with x0=123456 (defaults, real psdsqrt attached):
  - ack[0] and sq_start high for exactly 1 cycle at g+1;
  - sq_stop at g+22;
  - done[0] at g+24 with result=351;
  - busy high from g+1 to g+24.
- Simultaneous requests: req0 (x0=12) and req1 (x1=13) rise together -> requester 0 served first with result=3, then requester 1 with result=3; done[1] comes 25 cycles after done[0].
- Fairness: req0 and req1 held high across 4 services -> grant_id sequence is 0,1,0,1; no requester is starved.
- Operand stability: change x0 from 1057 to 4291 during RUN -> sq_xin stays 1057 and result=32.
- Reset mid-RUN: pull reset low for 3 cycles at g+10 -> sq_start, sq_stop and busy drop immediately, with no done. After release, re-issuing req0 with x0=4291 -> done[0] with result=65.
